// File: rtl/asi_pkg.sv
// Shared types and widths for the AXI slave user-side blocks.
package asi_pkg;

  localparam int AXI_AW     = 32;
  localparam int AXI_DW     = 32;
  localparam int AXI_WSTRBW = AXI_DW / 8;

  typedef enum logic [1:0] {IDLE, WBURST, RBURST} arb_state_e;
  typedef enum logic {OWN_WRITE, OWN_READ} owner_e;

  // Single requester wins outright; on a tie the side that did not own last wins.
  function automatic arb_state_e arb_pick(input logic wr, input logic rd, input owner_e last);
    arb_state_e pick;
    pick = IDLE;
    if (wr && rd)
      pick = (last == OWN_READ) ? WBURST : RBURST;
    else if (wr)
      pick = WBURST;
    else if (rd)
      pick = RBURST;
    return pick;
  endfunction

endpackage

// File: rtl/asi_ws_pipe.sv
// 1-bit wait-state delay line; DEPTH=0 degenerates to a wire.
module asi_ws_pipe #(
  parameter int DEPTH = 2
) (
  input  logic usr_clk,
  input  logic usr_reset,
  input  logic din,
  output logic dout,
  output logic any_set
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout    = din;
      assign any_set = 1'b0;
    end else begin : g_sr
      logic [DEPTH-1:0] sr;

      always_ff @(posedge usr_clk or posedge usr_reset) begin
        if (usr_reset) begin
          sr <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign dout    = sr[DEPTH-1];
      assign any_set = |sr;
    end
  endgenerate

endmodule

// File: rtl/asi_ram_arb.sv
// Single-port RAM arbiter: whole-burst round-robin between write and read streams,
// with a beat cap against starvation and a fixed-latency read-valid pipe.
//
//   state  | meaning
//   IDLE   | no owner, RAM disabled
//   WBURST | write stream owns the RAM
//   RBURST | read stream owns the RAM
module asi_ram_arb import asi_pkg::*; #(
  parameter int SLV_WS    = 2,
  parameter int MAX_BEATS = 16
) (
  input  logic                  usr_clk,
  input  logic                  usr_reset,
  input  logic                  w_req,
  output logic                  w_gnt,
  input  logic [AXI_AW-1:0]     w_addr,
  input  logic [AXI_DW-1:0]     w_data,
  input  logic [AXI_WSTRBW-1:0] w_strb,
  input  logic                  w_last,
  input  logic                  r_req,
  output logic                  r_gnt,
  input  logic [AXI_AW-1:0]     r_addr,
  input  logic                  r_last,
  output logic                  r_dvalid,
  output logic [AXI_DW-1:0]     r_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [AXI_AW-1:0]     ram_addr,
  output logic [AXI_DW-1:0]     ram_wdata,
  output logic [AXI_WSTRBW-1:0] ram_be,
  input  logic [AXI_DW-1:0]     ram_rdata,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_BEATS);

  arb_state_e       state, state_nxt;
  owner_e           last_owner, last_owner_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             cap_hit;
  logic             rd_issue;
  logic             pipe_busy;

  assign cap_hit = (beat_cnt == CNT_W'(MAX_BEATS - 1));

  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      state      <= IDLE;
      last_owner <= OWN_READ;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // The finishing owner's req on its last beat is that beat, not a new request,
  // so only the other side competes; a fresh burst from the same side goes via IDLE.
  always_comb begin
    state_nxt      = state;
    beat_cnt_nxt   = beat_cnt;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: state_nxt = arb_pick(w_req, r_req, last_owner);
      WBURST: if (w_req) begin
        beat_cnt_nxt = beat_cnt + 1'b1;
        if (w_last) begin
          beat_cnt_nxt = '0;
          state_nxt    = arb_pick(1'b0, r_req, OWN_WRITE);
        end else if (cap_hit && r_req) begin
          beat_cnt_nxt = '0;
          state_nxt    = RBURST;
        end
      end
      RBURST: if (r_req) begin
        beat_cnt_nxt = beat_cnt + 1'b1;
        if (r_last) begin
          beat_cnt_nxt = '0;
          state_nxt    = arb_pick(w_req, 1'b0, OWN_READ);
        end else if (cap_hit && w_req) begin
          beat_cnt_nxt = '0;
          state_nxt    = WBURST;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && state_nxt != state)
      last_owner_nxt = (state == WBURST) ? OWN_WRITE : OWN_READ;
  end

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_be    = '0;
    case (state)
      WBURST: begin
        ram_cs    = w_req;
        ram_we    = 1'b1;
        ram_addr  = w_addr;
        ram_wdata = w_data;
        ram_be    = w_strb;
      end
      RBURST: begin
        ram_cs   = r_req;
        ram_addr = r_addr;
        ram_be   = '1;
      end
      default: ;
    endcase
  end

  assign w_gnt    = (state == WBURST);
  assign r_gnt    = (state == RBURST);
  assign rd_issue = ram_cs && !ram_we;
  assign r_data   = ram_rdata;
  assign busy     = (state != IDLE) || pipe_busy;

  asi_ws_pipe #(.DEPTH(SLV_WS)) u_ws_pipe (
    .usr_clk   (usr_clk),
    .usr_reset (usr_reset),
    .din       (rd_issue),
    .dout      (r_dvalid),
    .any_set   (pipe_busy)
  );

endmodule

// File: tb/tb_asi_ram_arb.sv
// Self-checking bench for asi_ram_arb with a behavioural SRAM of matching read latency.
module tb_asi_ram_arb;
  import asi_pkg::*;

  localparam int SLV_WS    = 2;
  localparam int MAX_BEATS = 16;

  logic                  usr_clk = 1'b0;
  logic                  usr_reset;
  logic                  w_req, w_gnt, w_last;
  logic [AXI_AW-1:0]     w_addr;
  logic [AXI_DW-1:0]     w_data;
  logic [AXI_WSTRBW-1:0] w_strb;
  logic                  r_req, r_gnt, r_last, r_dvalid;
  logic [AXI_AW-1:0]     r_addr;
  logic [AXI_DW-1:0]     r_data;
  logic                  ram_cs, ram_we, busy;
  logic [AXI_AW-1:0]     ram_addr;
  logic [AXI_DW-1:0]     ram_wdata;
  logic [AXI_WSTRBW-1:0] ram_be;
  logic [AXI_DW-1:0]     ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [AXI_DW-1:0] exp_q[$];
  int                exp_cyc_q[$];
  int                exp_own_q[$];

  asi_ram_arb #(.SLV_WS(SLV_WS), .MAX_BEATS(MAX_BEATS)) dut (
    .usr_clk   (usr_clk),
    .usr_reset (usr_reset),
    .w_req     (w_req),
    .w_gnt     (w_gnt),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_strb    (w_strb),
    .w_last    (w_last),
    .r_req     (r_req),
    .r_gnt     (r_gnt),
    .r_addr    (r_addr),
    .r_last    (r_last),
    .r_dvalid  (r_dvalid),
    .r_data    (r_data),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_be    (ram_be),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 usr_clk = ~usr_clk;

  always @(posedge usr_clk) cyc <= cyc + 1;

  // SRAM model: write on the edge, read data appears SLV_WS(=2) cycles after the read.
  logic [AXI_DW-1:0] mem [0:1023];
  logic [AXI_DW-1:0] rd_d0, rd_d1;
  always @(posedge usr_clk) begin
    if (ram_cs && ram_we)
      for (int b = 0; b < AXI_WSTRBW; b++)
        if (ram_be[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    rd_d0 <= mem[ram_addr[11:2]];
    rd_d1 <= rd_d0;
  end
  assign ram_rdata = rd_d1;

  task automatic idle_inputs();
    w_req = 0; w_last = 0; w_addr = '0; w_data = '0; w_strb = '0;
    r_req = 0; r_last = 0; r_addr = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    usr_reset = 1;
    @(negedge usr_clk);
    usr_reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    usr_reset = 1;
    repeat (2) @(negedge usr_clk);
    n_checks++; if (w_gnt !== 1'b0)    begin n_fail++; $display("FAIL rst_w_gnt got %b exp 0", w_gnt); end
    n_checks++; if (r_gnt !== 1'b0)    begin n_fail++; $display("FAIL rst_r_gnt got %b exp 0", r_gnt); end
    n_checks++; if (r_dvalid !== 1'b0) begin n_fail++; $display("FAIL rst_r_dvalid got %b exp 0", r_dvalid); end
    n_checks++; if (ram_cs !== 1'b0)   begin n_fail++; $display("FAIL rst_ram_cs got %b exp 0", ram_cs); end
    n_checks++; if (ram_we !== 1'b0)   begin n_fail++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    usr_reset = 0;
  endtask

  task automatic test_write_burst();
    int beat, t_req;
    beat = 0;
    t_req = cyc;
    for (int it = 0; it < 20 && beat < 4; it++) begin
      w_req = 1; w_addr = 32'h100 + 4 * beat; w_data = 32'hA0 + beat;
      w_strb = '1; w_last = (beat == 3);
      #1;
      if (w_gnt) begin
        n_checks++; if (cyc !== t_req + 1 + beat) begin n_fail++; $display("FAIL wr_beat_cycle beat %0d got %0d exp %0d", beat, cyc, t_req + 1 + beat); end
        n_checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_cs_we beat %0d got cs=%b we=%b exp 1 1", beat, ram_cs, ram_we); end
        n_checks++; if (ram_addr !== 32'h100 + 4 * beat) begin n_fail++; $display("FAIL wr_addr beat %0d got %h exp %h", beat, ram_addr, 32'h100 + 4 * beat); end
        n_checks++; if (ram_wdata !== 32'hA0 + beat || ram_be !== 4'hF) begin n_fail++; $display("FAIL wr_data beat %0d got %h/%h exp %h/f", beat, ram_wdata, ram_be, 32'hA0 + beat); end
        beat++;
      end
      @(negedge usr_clk);
    end
    idle_inputs();
    #1;
    n_checks++; if (beat !== 4) begin n_fail++; $display("FAIL wr_beat_count got %0d exp 4", beat); end
    n_checks++; if (w_gnt !== 1'b0 || ram_cs !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle_after_last got gnt=%b cs=%b busy=%b exp 0 0 0", w_gnt, ram_cs, busy); end
    @(negedge usr_clk);
  endtask

  task automatic test_read_burst();
    int beat, last_gnt, last_busy, ec;
    logic [AXI_DW-1:0] e;
    beat = 0; last_gnt = -1; last_busy = -1;
    for (int it = 0; it < 12; it++) begin
      r_req = (beat < 4); r_addr = 32'h100 + 4 * beat; r_last = (beat == 3);
      #1;
      if (r_dvalid) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rd_unexpected_dvalid got data %h at cycle %0d exp none", r_data, cyc); end
        else begin
          e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
          if (r_data !== e || cyc !== ec + SLV_WS) begin n_fail++; $display("FAIL rd_return got %h@%0d exp %h@%0d", r_data, cyc, e, ec + SLV_WS); end
        end
      end
      if (r_req && r_gnt) begin
        n_checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h100 + 4 * beat) begin n_fail++; $display("FAIL rd_ram_drive beat %0d got cs=%b we=%b addr=%h exp 1 0 %h", beat, ram_cs, ram_we, ram_addr, 32'h100 + 4 * beat); end
        exp_q.push_back(32'hA0 + beat);
        exp_cyc_q.push_back(cyc);
        last_gnt = cyc;
        beat++;
      end
      if (busy) last_busy = cyc;
      @(negedge usr_clk);
    end
    idle_inputs();
    n_checks++; if (beat !== 4 || exp_q.size() != 0) begin n_fail++; $display("FAIL rd_completion got beats=%0d pending=%0d exp 4 0", beat, exp_q.size()); end
    n_checks++; if (last_busy !== last_gnt + SLV_WS) begin n_fail++; $display("FAIL rd_busy_drop got last busy cycle %0d exp %0d", last_busy, last_gnt + SLV_WS); end
    exp_q.delete(); exp_cyc_q.delete();
  endtask

  task automatic test_arb_both();
    logic [AXI_DW-1:0] e;
    pulse_reset();
    w_req = 1; w_addr = 32'h200; w_data = 32'hB0; w_strb = '1; w_last = 0;
    r_req = 1; r_addr = 32'h100; r_last = 1;
    #1;
    n_checks++; if (w_gnt !== 1'b0 || r_gnt !== 1'b0) begin n_fail++; $display("FAIL arb_first_cycle got w=%b r=%b exp 0 0", w_gnt, r_gnt); end
    @(negedge usr_clk); #1;
    n_checks++; if (w_gnt !== 1'b1 || r_gnt !== 1'b0) begin n_fail++; $display("FAIL arb_write_first got w=%b r=%b exp 1 0", w_gnt, r_gnt); end
    @(negedge usr_clk);
    w_addr = 32'h204; w_data = 32'hB1; w_last = 1;
    #1;
    n_checks++; if (w_gnt !== 1'b1) begin n_fail++; $display("FAIL arb_write_hold got w=%b exp 1", w_gnt); end
    @(negedge usr_clk);
    w_addr = 32'h208; w_data = 32'hB2; w_last = 1;
    #1;
    n_checks++; if (r_gnt !== 1'b1 || w_gnt !== 1'b0 || ram_cs !== 1'b1 || ram_addr !== 32'h100) begin n_fail++; $display("FAIL arb_read_no_bubble got r=%b w=%b cs=%b addr=%h exp 1 0 1 00000100", r_gnt, w_gnt, ram_cs, ram_addr); end
    exp_q.push_back(32'hA0);
    @(negedge usr_clk);
    r_req = 0; r_last = 0;
    #1;
    n_checks++; if (w_gnt !== 1'b1 || ram_addr !== 32'h208) begin n_fail++; $display("FAIL arb_write_again got w=%b addr=%h exp 1 00000208", w_gnt, ram_addr); end
    @(negedge usr_clk);
    w_req = 0; w_last = 0;
    #1;
    e = exp_q.pop_front();
    n_checks++; if (r_dvalid !== 1'b1 || r_data !== e) begin n_fail++; $display("FAIL arb_read_return got v=%b d=%h exp 1 %h", r_dvalid, r_data, e); end
    n_checks++; if (w_gnt !== 1'b0) begin n_fail++; $display("FAIL arb_idle_end got w=%b exp 0", w_gnt); end
    @(negedge usr_clk);
  endtask

  task automatic test_preempt();
    int wbeat, e;
    bit rdone;
    pulse_reset();
    wbeat = 0; rdone = 0;
    for (int i = 0; i < 16; i++) exp_own_q.push_back(i);
    exp_own_q.push_back(-1);
    for (int i = 16; i < 32; i++) exp_own_q.push_back(i);
    for (int it = 0; it < 50; it++) begin
      w_req = (wbeat < 32); w_addr = 32'h400 + 4 * wbeat; w_data = 32'h1000 + wbeat;
      w_strb = '1; w_last = (wbeat == 31);
      r_req = !rdone; r_addr = 32'h100; r_last = 1;
      #1;
      if (it >= 1 && it <= 33) begin
        n_checks++; if (ram_cs !== 1'b1) begin n_fail++; $display("FAIL pre_cs_continuous cycle %0d got %b exp 1", it, ram_cs); end
      end
      if ((w_req && w_gnt) || (r_req && r_gnt)) begin
        n_checks++;
        if (exp_own_q.size() == 0) begin n_fail++; $display("FAIL pre_extra_grant got w=%b r=%b exp none", w_gnt, r_gnt); end
        else begin
          e = exp_own_q.pop_front();
          if (w_gnt) begin
            if (e !== wbeat || ram_addr !== 32'h400 + 4 * wbeat) begin n_fail++; $display("FAIL pre_order got write beat %0d addr %h exp owner %0d", wbeat, ram_addr, e); end
            wbeat++;
          end else begin
            if (e !== -1) begin n_fail++; $display("FAIL pre_order got read exp write beat %0d", e); end
            rdone = 1;
          end
        end
      end
      @(negedge usr_clk);
    end
    idle_inputs();
    n_checks++; if (wbeat !== 32 || !rdone || exp_own_q.size() != 0) begin n_fail++; $display("FAIL pre_completion got wbeats=%0d rdone=%b pending=%0d exp 32 1 0", wbeat, rdone, exp_own_q.size()); end
    exp_own_q.delete();
  endtask

  task automatic test_long_read();
    int beat, t0, ec;
    logic [AXI_DW-1:0] e;
    beat = 0; t0 = cyc;
    for (int it = 0; it < 50; it++) begin
      r_req = (beat < 40); r_addr = 32'h400 + 4 * (beat % 32); r_last = (beat == 39);
      #1;
      if (r_dvalid) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL long_unexpected_dvalid got %h exp none", r_data); end
        else begin
          e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
          if (r_data !== e || cyc !== ec + SLV_WS) begin n_fail++; $display("FAIL long_return got %h@%0d exp %h@%0d", r_data, cyc, e, ec + SLV_WS); end
        end
      end
      if (r_req && r_gnt) begin
        n_checks++; if (cyc !== t0 + 1 + beat || w_gnt !== 1'b0) begin n_fail++; $display("FAIL long_contiguous beat %0d got cycle %0d exp %0d", beat, cyc, t0 + 1 + beat); end
        exp_q.push_back(32'h1000 + (beat % 32));
        exp_cyc_q.push_back(cyc);
        beat++;
      end
      @(negedge usr_clk);
    end
    idle_inputs();
    n_checks++; if (beat !== 40 || exp_q.size() != 0) begin n_fail++; $display("FAIL long_completion got beats=%0d pending=%0d exp 40 0", beat, exp_q.size()); end
    exp_q.delete(); exp_cyc_q.delete();
  endtask

  task automatic test_reset_inflight();
    int seen, ec;
    logic [AXI_DW-1:0] e;
    seen = 0;
    r_req = 1; r_addr = 32'h100; r_last = 0;
    @(negedge usr_clk); #1;
    n_checks++; if (r_gnt !== 1'b1) begin n_fail++; $display("FAIL rstf_first_gnt got %b exp 1", r_gnt); end
    r_addr = 32'h104; r_last = 1;
    @(posedge usr_clk);
    @(posedge usr_clk); #1;
    usr_reset = 1;
    idle_inputs();
    #1;
    n_checks++; if (r_dvalid !== 1'b0 || r_gnt !== 1'b0 || w_gnt !== 1'b0) begin n_fail++; $display("FAIL rstf_immediate got v=%b r=%b w=%b exp 0 0 0", r_dvalid, r_gnt, w_gnt); end
    n_checks++; if (busy !== 1'b0 || ram_cs !== 1'b0) begin n_fail++; $display("FAIL rstf_busy got busy=%b cs=%b exp 0 0", busy, ram_cs); end
    @(posedge usr_clk); #1;
    usr_reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge usr_clk);
      if (r_dvalid || busy) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstf_no_stale_dvalid got %0d active cycles exp 0", seen); end
    r_req = 1; r_addr = 32'h104; r_last = 1;
    @(negedge usr_clk); #1;
    n_checks++; if (r_gnt !== 1'b1) begin n_fail++; $display("FAIL rstf_new_gnt got %b exp 1", r_gnt); end
    exp_q.push_back(32'hA1); exp_cyc_q.push_back(cyc);
    @(negedge usr_clk);
    r_req = 0; r_last = 0;
    @(negedge usr_clk); #1;
    e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
    n_checks++; if (r_dvalid !== 1'b1 || r_data !== e || cyc !== ec + SLV_WS) begin n_fail++; $display("FAIL rstf_new_return got v=%b d=%h@%0d exp 1 %h@%0d", r_dvalid, r_data, cyc, e, ec + SLV_WS); end
    @(negedge usr_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    usr_reset = 1;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_arb_both();
    test_preempt();
    test_long_read();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
